// File: rtl/srcd_pkg.sv
// Shared types and helpers for the srcd operand-latch stage.
// Holds state encoding, default sizes and operand-select priority.
package srcd_pkg;

    localparam int SRCD_DW    = 32;
    localparam int SRCD_NREGS = 32;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        WAIT
    } state_t;

    typedef enum logic [2:0] {
        SEL_LOC,
        SEL_LDWB,
        SEL_WB,
        SEL_WAIT,
        SEL_RF
    } sel_t;

    function automatic sel_t op_sel(
        input logic loc,
        input logic ld_hit,
        input logic wb_hit,
        input logic pend
    );
        sel_t s;
        s = SEL_RF;
        if (loc)         s = SEL_LOC;
        else if (ld_hit) s = SEL_LDWB;
        else if (wb_hit) s = SEL_WB;
        else if (pend)   s = SEL_WAIT;
        return s;
    endfunction

endpackage

// File: rtl/srcd_operand_stage_if.sv
// Issue, forwarding, load-return and ALU handshake bundle for the
// srcd operand-latch stage.
interface srcd_operand_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
) ();
    logic          flush;
    logic          ins_valid;
    logic          ins_ready;
    logic [AW-1:0] srcaddr;
    logic          locdent;
    logic [DW-1:0] locsrc;
    logic [DW-1:0] srcd_rf;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          ld_issue;
    logic [AW-1:0] ld_addr;
    logic          ld_wb_en;
    logic [AW-1:0] ld_wb_addr;
    logic [DW-1:0] ld_wb_data;
    logic          srcd_valid;
    logic [DW-1:0] srcd;
    logic          alu_ready;

    modport master (
        output flush, ins_valid, srcaddr, locdent, locsrc, srcd_rf,
        output wb_en, wb_addr, wb_data, ld_issue, ld_addr,
        output ld_wb_en, ld_wb_addr, ld_wb_data, alu_ready,
        input  ins_ready, srcd_valid, srcd
    );

    modport slave (
        input  flush, ins_valid, srcaddr, locdent, locsrc, srcd_rf,
        input  wb_en, wb_addr, wb_data, ld_issue, ld_addr,
        input  ld_wb_en, ld_wb_addr, ld_wb_data, alu_ready,
        output ins_ready, srcd_valid, srcd
    );
endinterface

// File: rtl/srcd_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared on load return; a same-cycle set beats the clear.
module srcd_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_set,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_raddr,
    output logic          o_pending
);
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    assign w_set = i_set ? (NREGS'(1) << i_set_addr) : '0;
    assign w_clr = i_clr ? (NREGS'(1) << i_clr_addr) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pending <= '0;
        else       r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign o_pending = r_pending[i_raddr];
endmodule

// File: rtl/srcd_operand_stage.sv
// Operand latch after srcdgen: picks local, forwarded or register data,
// holds it for the ALU, and parks in WAIT while a needed load is pending.
module srcd_operand_stage
    import srcd_pkg::*;
#(
    parameter int DW    = SRCD_DW,
    parameter int NREGS = SRCD_NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic sys_clk,
    input  logic reset,
    srcd_operand_stage_if.slave bus
);
    state_t        r_state, w_state_nx;
    logic [DW-1:0] r_srcd, w_srcd_nx;
    logic [AW-1:0] r_addr, w_addr_nx;

    logic          w_pending;
    logic          w_accept;
    logic          w_ld_hit;
    logic          w_wb_hit;
    logic          w_wait_hit;
    sel_t          w_sel;

    srcd_scoreboard #(.NREGS(NREGS)) u_sb (
        .i_clk      (sys_clk),
        .i_rst      (reset),
        .i_set      (bus.ld_issue),
        .i_set_addr (bus.ld_addr),
        .i_clr      (bus.ld_wb_en),
        .i_clr_addr (bus.ld_wb_addr),
        .i_raddr    (bus.srcaddr),
        .o_pending  (w_pending)
    );

    assign bus.ins_ready = !reset &&
        (r_state == EMPTY || (r_state == FULL && bus.alu_ready));
    assign bus.srcd_valid = (r_state == FULL);
    assign bus.srcd       = r_srcd;

    assign w_accept   = bus.ins_valid && bus.ins_ready && !bus.flush;
    assign w_ld_hit   = bus.ld_wb_en && bus.ld_wb_addr == bus.srcaddr;
    assign w_wb_hit   = bus.wb_en && bus.wb_addr == bus.srcaddr;
    assign w_wait_hit = bus.ld_wb_en && bus.ld_wb_addr == r_addr;
    assign w_sel      = op_sel(bus.locdent, w_ld_hit, w_wb_hit, w_pending);

    always_comb begin
        w_state_nx = r_state;
        w_srcd_nx  = r_srcd;
        w_addr_nx  = r_addr;
        if (bus.flush) begin
            w_state_nx = EMPTY;
        end else if (w_accept) begin
            w_state_nx = FULL;
            case (w_sel)
                SEL_LOC:  w_srcd_nx = bus.locsrc;
                SEL_LDWB: w_srcd_nx = bus.ld_wb_data;
                SEL_WB:   w_srcd_nx = bus.wb_data;
                SEL_WAIT: begin
                    w_state_nx = WAIT;
                    w_addr_nx  = bus.srcaddr;
                end
                default:  w_srcd_nx = bus.srcd_rf;
            endcase
        end else if (r_state == FULL && bus.alu_ready) begin
            w_state_nx = EMPTY;
        end else if (r_state == WAIT && w_wait_hit) begin
            w_state_nx = FULL;
            w_srcd_nx  = bus.ld_wb_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_srcd  <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_srcd  <= w_srcd_nx;
            r_addr  <= w_addr_nx;
        end
    end
endmodule

// File: tb/tb_srcd_operand_stage.sv
// Self-checking bench for srcd_operand_stage: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_srcd_operand_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_chk   = 0;
    int   n_err   = 0;

    srcd_operand_stage_if #(.DW(DW), .AW(AW)) bus ();

    srcd_operand_stage dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: "have an operand", "waiting for a load", the
    // operand value and a set of registers with loads in flight.
    bit        m_has;
    bit        m_wait;
    bit [31:0] m_val;
    int        m_waddr;
    bit        m_pend [32];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        if (reset) return 1'b0;
        if (m_wait) return 1'b0;
        if (!m_has) return 1'b1;
        return bus.alu_ready;
    endfunction

    task automatic model_edge();
        bit acc;
        int a;
        if (reset) begin
            m_has = 0; m_wait = 0; m_val = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
            return;
        end
        acc = bus.ins_valid && exp_ready() && !bus.flush;
        a   = int'(bus.srcaddr);
        if (bus.flush) begin
            m_has = 0; m_wait = 0;
        end else if (acc) begin
            m_has = 1; m_wait = 0;
            if (bus.locdent) m_val = bus.locsrc;
            else if (bus.ld_wb_en && int'(bus.ld_wb_addr) == a)
                m_val = bus.ld_wb_data;
            else if (bus.wb_en && int'(bus.wb_addr) == a)
                m_val = bus.wb_data;
            else if (m_pend[a]) begin
                m_has = 0; m_wait = 1; m_waddr = a;
            end else m_val = bus.srcd_rf;
        end else if (m_has && bus.alu_ready) begin
            m_has = 0;
        end else if (m_wait && bus.ld_wb_en &&
                     int'(bus.ld_wb_addr) == m_waddr) begin
            m_wait = 0; m_has = 1; m_val = bus.ld_wb_data;
        end
        if (bus.ld_wb_en) m_pend[int'(bus.ld_wb_addr)] = 0;
        if (bus.ld_issue) m_pend[int'(bus.ld_addr)] = 1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.ins_valid = 0; bus.srcaddr = '0;
        bus.locdent = 0; bus.locsrc = '0; bus.srcd_rf = '0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.ld_issue = 0; bus.ld_addr = '0;
        bus.ld_wb_en = 0; bus.ld_wb_addr = '0; bus.ld_wb_data = '0;
        bus.alu_ready = 0;
    endtask

    task automatic tick(input string tag);
        #1;
        check({tag, ".ready"}, 32'(bus.ins_ready), 32'(exp_ready()));
        @(posedge sys_clk);
        model_edge();
        #1;
        check({tag, ".valid"}, 32'(bus.srcd_valid), 32'(m_has));
        if (m_has) check({tag, ".srcd"}, bus.srcd, m_val);
    endtask

    task automatic issue(input int a, input logic [31:0] rf);
        bus.ins_valid = 1; bus.srcaddr = AW'(a); bus.srcd_rf = rf;
    endtask

    initial begin
        idle();
        // 1: reset
        reset = 1;
        tick("rst0");
        tick("rst1");
        check("rst.srcd", bus.srcd, 32'h0);
        reset = 0;
        tick("rst_rel");

        // 2: locdent overrides pending
        bus.ld_issue = 1; bus.ld_addr = 5'd2;
        tick("ld2");
        idle();
        issue(2, 32'h5555); bus.locdent = 1; bus.locsrc = 32'h1F;
        tick("loc");
        check("loc.val", bus.srcd, 32'h1F);
        idle(); bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd2; bus.alu_ready = 1;
        tick("clr2");

        // 3: forwarding priority
        idle(); issue(5, 32'h1111);
        bus.wb_en = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h2222;
        tick("wbfwd");
        check("wbfwd.val", bus.srcd, 32'h2222);
        bus.alu_ready = 1;
        bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd5; bus.ld_wb_data = 32'h3333;
        tick("ldfwd");
        check("ldfwd.val", bus.srcd, 32'h3333);

        // 4: wait on a pending load
        idle(); bus.alu_ready = 1; bus.ld_issue = 1; bus.ld_addr = 5'd7;
        tick("ld7");
        idle(); issue(7, 32'h7777);
        tick("acc7");
        idle(); bus.ins_valid = 1;
        for (int i = 0; i < 3; i++) tick("wait7");
        check("wait7.rdy", 32'(bus.ins_ready), 32'h0);
        idle(); bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd7;
        bus.ld_wb_data = 32'hCAFE;
        tick("ret7");
        check("ret7.val", bus.srcd, 32'hCAFE);
        idle(); bus.alu_ready = 1;
        tick("drain7");
        idle(); issue(7, 32'h0707);
        tick("r7free");
        check("r7free.val", bus.srcd, 32'h0707);

        // 5: frozen operand, then back-to-back issue
        idle(); bus.alu_ready = 1;
        tick("drain");
        idle(); bus.locdent = 1; bus.locsrc = 32'hAA; bus.ins_valid = 1;
        tick("aa");
        idle(); bus.wb_en = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'hBB;
        for (int i = 0; i < 4; i++) tick("freeze");
        check("freeze.val", bus.srcd, 32'hAA);
        idle(); bus.alu_ready = 1; issue(9, 32'hCC);
        tick("b2b");
        check("b2b.val", bus.srcd, 32'hCC);

        // 6: flush in WAIT, same-cycle set/clear
        idle(); bus.alu_ready = 1; bus.ld_issue = 1; bus.ld_addr = 5'd4;
        tick("ld4");
        idle(); issue(4, 32'h4);
        tick("acc4");
        idle(); bus.flush = 1;
        tick("flush");
        idle();
        tick("post_flush");
        check("flush.rdy", 32'(bus.ins_ready), 32'h1);
        bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd4;
        tick("clr4");
        idle(); bus.ld_issue = 1; bus.ld_addr = 5'd3;
        bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd3;
        tick("setclr3");
        idle(); issue(3, 32'h3);
        tick("acc3");
        check("pend3.wait", 32'(bus.srcd_valid), 32'h0);
        idle(); bus.ld_wb_en = 1; bus.ld_wb_addr = 5'd3;
        bus.ld_wb_data = 32'h3D;
        tick("ret3");

        // random traffic over a small register window
        for (int c = 0; c < 600; c++) begin
            int a;
            idle();
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.ins_valid = $urandom_range(0, 1);
            bus.srcaddr   = AW'($urandom_range(0, 3));
            bus.locdent   = ($urandom_range(0, 4) == 0);
            bus.locsrc    = $urandom;
            bus.srcd_rf   = $urandom;
            bus.wb_en     = $urandom_range(0, 1);
            bus.wb_addr   = AW'($urandom_range(0, 3));
            bus.wb_data   = $urandom;
            bus.ld_wb_en  = ($urandom_range(0, 2) == 0);
            bus.ld_wb_addr = AW'($urandom_range(0, 3));
            bus.ld_wb_data = $urandom;
            bus.alu_ready = $urandom_range(0, 1);
            a = $urandom_range(0, 3);
            if (!m_pend[a] && $urandom_range(0, 3) == 0) begin
                bus.ld_issue = 1; bus.ld_addr = AW'(a);
            end
            reset = ($urandom_range(0, 199) == 0);
            tick("rnd");
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
